// File: rtl/mc_core_seq_if.sv
// mc_core_seq_if: memory-side handshake bundle for the multi-cycle sequencer.
//   master modport : sequencer side (drives requests, receives acks/data)
//   slave modport  : memory side (drives acks/data, receives requests)
// Signals:
//   imem_req/imem_addr -> , <- imem_ack/imem_rdata : instruction fetch
//   dmem_req/dmem_we   -> , <- dmem_ack            : data load/store
//
// Handshake: a request is held high until the cycle its ack is seen. The
// transfer completes in any cycle where req and ack are both high, and this
// includes the first cycle of the request (zero wait). An ack while req is low
// carries no meaning and is ignored. Fetch data is valid only in the imem_ack
// cycle.
interface mc_core_seq_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/mc_core_seq.sv
// mc_core_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I core
// with variable-latency instruction and data memories.
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   bus                 memory handshake bundle (mc_core_seq_if.master)
//   is_load, is_store   external decode of ir
//   rf_we_dec           external decoded RF write enable
//   npc, wd             external next-PC and write-back data
//   ir, pc, instret     instruction register, program counter, retire count
//   rf_we               RF write strobe, only in WB, suppressed for stores
//   bus_err             sticky error: memory timeout or misaligned npc
//   debug_wb_*          retire trace, zero outside WB
//   state_dbg           current FSM state encoding
module mc_core_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_core_seq_if.master     bus,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              rf_we_dec,
  input  logic [XLEN-1:0]   npc,
  input  logic [XLEN-1:0]   wd,
  output logic [31:0]       ir,
  output logic [XLEN-1:0]   pc,
  output logic              rf_we,
  output logic              bus_err,
  output logic [31:0]       instret,
  output logic              debug_wb_have_inst,
  output logic [XLEN-1:0]   debug_wb_pc,
  output logic              debug_wb_ena,
  output logic [4:0]        debug_wb_reg,
  output logic [XLEN-1:0]   debug_wb_value,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam int             WCW      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

  state_t         state, state_next;
  logic [WCW-1:0] wait_cnt;
  logic           wait_expired;
  logic           npc_misaligned;
  logic           in_wb;

  // The last allowed request cycle is the one where wait_cnt has reached the
  // limit; a missing ack there is the timeout. MAX_WAIT=0 disables it.
  assign wait_expired   = (MAX_WAIT != 0) && (wait_cnt == WAIT_LIM);
  assign npc_misaligned = |npc[1:0];
  assign in_wb          = (state == S_WB);

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (bus.imem_ack)      state_next = S_DECODE;
        else if (wait_expired) state_next = S_ERR;
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC:   state_next = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ack)      state_next = S_WB;
        else if (wait_expired) state_next = S_ERR;
      end
      S_WB:     state_next = npc_misaligned ? S_ERR : S_FETCH;
      S_ERR:    state_next = S_ERR;
      default:  state_next = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      pc       <= RESET_PC;
      ir       <= '0;
      instret  <= '0;
      bus_err  <= 1'b0;
    end else begin
      state <= state_next;

      // Counts request cycles without ack; any state change restarts it.
      if (state_next != state)
        wait_cnt <= '0;
      else if ((MAX_WAIT != 0) && (state == S_FETCH || state == S_MEM))
        wait_cnt <= wait_cnt + 1'b1;

      if (state == S_FETCH && bus.imem_ack)
        ir <= bus.imem_rdata;

      // A misaligned npc still retires the instruction but keeps the old pc.
      if (in_wb) begin
        instret <= instret + 32'd1;
        if (!npc_misaligned)
          pc <= npc;
      end

      if (state_next == S_ERR)
        bus_err <= 1'b1;
    end
  end

  // The state register resets to FETCH, so the fetch request is additionally
  // qualified by rst_n to stay low while reset is held.
  assign bus.imem_req  = rst_n && (state == S_FETCH);
  assign bus.imem_addr = pc;
  assign bus.dmem_req  = (state == S_MEM);
  assign bus.dmem_we   = (state == S_MEM) && is_store;

  assign rf_we              = in_wb && rf_we_dec && !is_store;
  assign debug_wb_have_inst = in_wb;
  assign debug_wb_pc        = in_wb ? pc : '0;
  assign debug_wb_ena       = rf_we;
  assign debug_wb_reg       = in_wb ? ir[11:7] : 5'd0;
  assign debug_wb_value     = in_wb ? wd : '0;
  assign state_dbg          = state;

endmodule

// File: tb/tb_mc_core_seq.sv
// tb_mc_core_seq: directed bench for mc_core_seq. The bench plays the
// instruction decoder and both memories; a cycle-level expectation (request
// windows, retire cycle and trace contents per instruction) is derived from
// wait counts and compared against the DUT every cycle.
module tb_mc_core_seq;
  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 15;
  // expected retire record: {cycle, pc, rd, value, ena, npc}
  localparam int EW       = 32 + 32 + 5 + 32 + 1 + 32;
  localparam int NO_ERR   = 32'h7fffffff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  mc_core_seq_if #(.XLEN(XLEN)) bus ();

  logic            is_load, is_store, rf_we_dec;
  logic [XLEN-1:0] npc, wd;
  logic [31:0]     ir, instret;
  logic [XLEN-1:0] pc, debug_wb_pc, debug_wb_value;
  logic            rf_we, bus_err, debug_wb_have_inst, debug_wb_ena;
  logic [4:0]      debug_wb_reg;
  logic [2:0]      state_dbg;

  mc_core_seq #(.XLEN(XLEN), .RESET_PC(32'h0), .MAX_WAIT(MAX_WAIT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus.master),
    .is_load            (is_load),
    .is_store           (is_store),
    .rf_we_dec          (rf_we_dec),
    .npc                (npc),
    .wd                 (wd),
    .ir                 (ir),
    .pc                 (pc),
    .rf_we              (rf_we),
    .bus_err            (bus_err),
    .instret            (instret),
    .debug_wb_have_inst (debug_wb_have_inst),
    .debug_wb_pc        (debug_wb_pc),
    .debug_wb_ena       (debug_wb_ena),
    .debug_wb_reg       (debug_wb_reg),
    .debug_wb_value     (debug_wb_value),
    .state_dbg          (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_pass = 0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   m_pc, m_instret;
  int            err_cyc;
  bit            act, chk_en;
  int            cur_f, cur_iw, cur_dw;
  bit            cur_mem, cur_st;
  int            i_cnt, d_cnt;
  int            ireq_cnt, dreq_cnt, dwe_cnt, rfwe_cnt;
  int            ret_cyc[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
  endtask

  // ---------------- driver tasks ----------------
  // Memory responder: ack a request after the configured number of wait cycles.
  task automatic drive_acks();
    if (bus.imem_req) begin
      bus.imem_ack = (i_cnt == cur_iw);
      i_cnt++;
    end else begin
      bus.imem_ack = 1'b0;
      i_cnt = 0;
    end
    if (bus.dmem_req) begin
      bus.dmem_ack = (d_cnt == cur_dw);
      d_cnt++;
    end else begin
      bus.dmem_ack = 1'b0;
      d_cnt = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive_acks();
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    exp_q.delete();
    act = 1'b0;
    m_pc = 32'h0;
    m_instret = 32'h0;
    err_cyc = NO_ERR;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic release_rst();
    rst_n = 1'b1;
    #1;
    chk_en = 1'b1;
  endtask

  // Called at the start of the DUT's FETCH cycle (before acks are driven).
  // iw/dw: wait cycles before imem/dmem ack; abort>0 stops after that many cycles.
  task automatic run_inst(input logic [31:0] rdata, input bit ld, input bit st,
                          input bit we, input logic [31:0] n, input logic [31:0] w,
                          input int iw, input int dw, input int abort);
    int last;
    int r;
    imem_rdata_set(rdata);
    is_load = ld; is_store = st; rf_we_dec = we; npc = n; wd = w;
    cur_f = cyc; cur_iw = iw; cur_dw = dw; cur_mem = ld | st; cur_st = st; act = 1'b1;
    if (iw > MAX_WAIT) begin
      err_cyc = cyc + MAX_WAIT + 1;
      last = err_cyc + 1;
    end else begin
      r = cyc + iw + 3 + ((ld | st) ? (1 + dw) : 0);
      exp_q.push_back({32'(r), m_pc, rdata[11:7], w, we & ~st, n});
      last = r;
    end
    while (cyc <= last && (abort == 0 || cyc < cur_f + abort)) begin
      drive_acks();
      @(posedge clk); #1;
    end
  endtask

  task automatic imem_rdata_set(input logic [31:0] v);
    bus.imem_rdata = v;
  endtask

  // ---------------- compare process ----------------
  logic [EW-1:0] rec;
  bit eh, eerr, eir, edr;
  int fe, ms, me;

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      eerr = (cyc >= err_cyc);
      fe   = cur_f + ((cur_iw > MAX_WAIT) ? MAX_WAIT : cur_iw);
      eir  = act && !eerr && cyc >= cur_f && cyc <= fe;
      ms   = cur_f + cur_iw + 3;
      me   = ms + cur_dw;
      edr  = act && !eerr && cur_mem && (cur_iw <= MAX_WAIT) && cyc >= ms && cyc <= me;
      chk("imem_req", bus.imem_req, eir);
      if (eir) chk("imem_addr", bus.imem_addr, m_pc);
      chk("dmem_req", bus.dmem_req, edr);
      chk("dmem_we", bus.dmem_we, edr & cur_st);
      eh = (exp_q.size() > 0) && (exp_q[0][EW-1 -: 32] == cyc);
      chk("have_inst", debug_wb_have_inst, eh);
      if (eh) begin
        rec = exp_q.pop_front();
        chk("wb_pc", debug_wb_pc, rec[101:70]);
        chk("wb_reg", debug_wb_reg, rec[69:65]);
        chk("wb_value", debug_wb_value, rec[64:33]);
        chk("wb_ena", debug_wb_ena, rec[32]);
        chk("rf_we", rf_we, rec[32]);
      end else begin
        chk("rf_we_idle", rf_we, 1'b0);
        chk("debug_idle", {31'd0, debug_wb_ena | (|debug_wb_pc) | (|debug_wb_reg) | (|debug_wb_value)}, 32'd0);
      end
      chk("instret", instret, m_instret);
      chk("pc", pc, m_pc);
      chk("bus_err", bus_err, eerr);
      if (bus.imem_req) ireq_cnt++;
      if (bus.dmem_req) dreq_cnt++;
      if (bus.dmem_req && bus.dmem_we) dwe_cnt++;
      if (rf_we) rfwe_cnt++;
      if (debug_wb_have_inst) ret_cyc.push_back(cyc);
      if (eh) begin
        m_instret = m_instret + 32'd1;
        if (rec[1:0] == 2'b00) m_pc = rec[31:0];
        else err_cyc = cyc + 1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [31:0] ADDI_X1_5 = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] LW_X2     = 32'h00002103;  // lw x2,0(x0)
  localparam logic [31:0] SW_X2     = 32'h00202223;  // sw x2,4(x0)
  int f0;

  initial begin
    is_load = 1'b0; is_store = 1'b0; rf_we_dec = 1'b0; npc = '0; wd = '0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = '0;
    cur_f = 0; cur_iw = 0; cur_dw = 0; cur_mem = 1'b0; cur_st = 1'b0;
    i_cnt = 0; d_cnt = 0; ireq_cnt = 0; dreq_cnt = 0; dwe_cnt = 0; rfwe_cnt = 0;

    // reset state
    do_reset();
    chk("rst_imem_req", bus.imem_req, 1'b0);
    chk("rst_dmem_req", bus.dmem_req, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    release_rst();

    // 1: three zero-wait ADDI
    ret_cyc.delete();
    for (int i = 0; i < 3; i++)
      run_inst(ADDI_X1_5, 1'b0, 1'b0, 1'b1, m_pc + 32'd4, 32'd5, 0, 0, 0);
    chk("t1_instret", instret, 32'd3);
    chk("t1_pc", pc, 32'hc);
    chk("t1_ir", ir, ADDI_X1_5);
    chk("t1_spacing", ret_cyc[1] - ret_cyc[0], 32'd4);

    // 2: load with 3 data wait cycles
    dreq_cnt = 0; rfwe_cnt = 0; ret_cyc.delete(); f0 = cyc;
    run_inst(LW_X2, 1'b1, 1'b0, 1'b1, m_pc + 32'd4, 32'hdeadbeef, 0, 3, 0);
    chk("t2_dreq_cycles", dreq_cnt, 32'd4);
    chk("t2_rf_we_count", rfwe_cnt, 32'd1);
    chk("t2_retire_offset", ret_cyc[0] - f0, 32'd7);
    chk("t2_pc", pc, 32'h10);

    // 3: store, decoder also (wrongly) asserting rf_we_dec: must stay gated
    dwe_cnt = 0; rfwe_cnt = 0; ret_cyc.delete();
    run_inst(SW_X2, 1'b0, 1'b1, 1'b1, m_pc + 32'd4, 32'h12345678, 0, 1, 0);
    chk("t3_dwe_cycles", dwe_cnt, 32'd2);
    chk("t3_rf_we_count", rfwe_cnt, 32'd0);
    chk("t3_retires", ret_cyc.size(), 32'd1);

    // 4: fetch acked on the 16th request cycle, then a fetch that never acks
    ireq_cnt = 0;
    run_inst(ADDI_X1_5, 1'b0, 1'b0, 1'b1, m_pc + 32'd4, 32'd5, 15, 0, 0);
    chk("t4_ireq_cycles_ok", ireq_cnt, 32'd16);
    chk("t4_bus_err_ok", bus_err, 1'b0);
    ireq_cnt = 0;
    run_inst(ADDI_X1_5, 1'b0, 1'b0, 1'b1, m_pc + 32'd4, 32'd5, 1000, 0, 0);
    idle(3);
    chk("t4_ireq_cycles_to", ireq_cnt, 32'd16);
    chk("t4_bus_err", bus_err, 1'b1);
    chk("t4_imem_req_err", bus.imem_req, 1'b0);
    chk("t4_instret", instret, 32'd6);

    // 5: misaligned npc
    do_reset();
    release_rst();
    run_inst(ADDI_X1_5, 1'b0, 1'b0, 1'b1, m_pc + 32'd4, 32'd5, 0, 0, 0);
    run_inst(ADDI_X1_5, 1'b0, 1'b0, 1'b1, 32'h6, 32'd5, 0, 0, 0);
    ireq_cnt = 0;
    idle(4);
    chk("t5_bus_err", bus_err, 1'b1);
    chk("t5_pc", pc, 32'h4);
    chk("t5_instret", instret, 32'd2);
    chk("t5_no_fetch", ireq_cnt, 32'd0);

    // 6: reset in the middle of a data access
    do_reset();
    release_rst();
    run_inst(ADDI_X1_5, 1'b0, 1'b0, 1'b1, m_pc + 32'd4, 32'd5, 0, 0, 0);
    run_inst(LW_X2, 1'b1, 1'b0, 1'b1, m_pc + 32'd4, 32'h55, 0, 10, 5);
    chk("t6_in_mem", bus.dmem_req, 1'b1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_dmem_req", bus.dmem_req, 1'b0);
    chk("t6_rst_imem_req", bus.imem_req, 1'b0);
    chk("t6_rst_rf_we", rf_we, 1'b0);
    chk("t6_rst_have_inst", debug_wb_have_inst, 1'b0);
    chk("t6_rst_pc", pc, 32'h0);
    chk("t6_rst_instret", instret, 32'h0);
    do_reset();
    release_rst();
    chk("t6_restart_fetch", bus.imem_req, 1'b1);
    run_inst(ADDI_X1_5, 1'b0, 1'b0, 1'b1, m_pc + 32'd4, 32'd5, 0, 0, 0);
    chk("t6_pc", pc, 32'h4);
    chk("t6_instret", instret, 32'd1);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
